// File: rtl/frame_reorder_pkg.sv
// Shared definitions for the frame reorder buffer.
//   MODE_*    : per-frame permutation encodings (value 3 is reserved and
//               treated as natural order)
//   perm_addr : maps an output index to the bank address to read
package frame_reorder_pkg;

  localparam logic [1:0] MODE_NAT  = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_BREV = 2'd2;

  // Index width handled by perm_addr; callers truncate to LOG2N bits.
  localparam int PERM_W = 16;

  // Output index i of a frame of 2^log2n samples reads bank address a:
  //   natural        : a = i
  //   half-interleave: a = {i[0], i[log2n-1:1]}  (perfect shuffle of halves)
  //   bit-reverse    : a = i reversed over log2n bits
  function automatic logic [PERM_W-1:0] perm_addr(input logic [1:0]        mode,
                                                  input logic [PERM_W-1:0] i,
                                                  input int                log2n);
    logic [PERM_W-1:0] a;
    a = i;
    case (mode)
      MODE_HALF: a = (i >> 1) | (PERM_W'(i[0]) << (log2n - 1));
      MODE_BREV: begin
        a = '0;
        for (int b = 0; b < log2n; b++) a[log2n - 1 - b] = i[b];
      end
      default:   a = i;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/frame_reorder_sdp_ram.sv
// Simple dual-port synchronous RAM shared by the FFT stages.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable, rdata = mem[raddr] one cycle later (held otherwise)
// Depth is 2^AW words of DW bits. Contents are not reset.
module sdp_ram #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1 << AW];

  // NOTE: the array has no reset branch so it maps onto block RAM; readers
  // only ever see words that were written after the bank was last filled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_reorder.sv
// Ping-pong frame buffer that emits each N = 2^LOG2N sample frame permuted.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : writer handshake, in_data carries CH channels of
//                           DBW bits, in_mode selects the frame permutation
//                           (sampled with the first sample of the frame)
//   out_valid/out_ready   : reader handshake, out_data is the permuted sample,
//                           out_first/out_last mark output index 0 / N-1
// The writer fills one bank while the reader drains the other. Reads go
// through a one-cycle RAM into a two-entry output skid, so the reader runs at
// one sample per cycle and out_* hold steady under backpressure.
module frame_reorder
  import frame_reorder_pkg::*;
#(
  parameter int DBW   = 16,
  parameter int CH    = 1,
  parameter int LOG2N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DBW*CH-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DBW*CH-1:0] out_data,
  output logic              out_first,
  output logic              out_last
);

  localparam int                W        = DBW * CH;
  localparam logic [LOG2N-1:0]  LAST_IDX = '1;

  // Write side
  logic [LOG2N-1:0]  wr_cnt;
  logic              wr_bank;
  logic [1:0][1:0]   bank_mode;
  logic              wr_fire;

  // Read side
  logic [1:0]        full;
  logic [LOG2N-1:0]  rd_cnt;
  logic              rd_bank;
  logic              rd_issue;
  logic [LOG2N-1:0]  rd_addr;
  logic [W-1:0]      rd_data;

  // Output pipe: RAM output stage (pend), then head (out_*) and skid entry
  logic              pend_valid, pend_first, pend_last;
  logic              skid_valid, skid_first, skid_last;
  logic [W-1:0]      skid_data;
  logic              pop;
  logic [2:0]        inflight;

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Every issued read must find a slot in head/skid even if the consumer
  // stalls from now on, so count what is already committed minus this pop.
  assign inflight = 3'(out_valid) + 3'(skid_valid) + 3'(pend_valid);
  assign rd_issue = full[rd_bank] && ((inflight - 3'(pop)) < 3'd2);
  assign rd_addr  = LOG2N'(perm_addr(bank_mode[rd_bank], PERM_W'(rd_cnt), LOG2N));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      bank_mode <= '0;
    end else if (wr_fire) begin
      if (wr_cnt == '0) bank_mode[wr_bank] <= in_mode;
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == LAST_IDX) wr_bank <= !wr_bank;
    end
  end

  // The writer and reader always own opposite banks when both act on their
  // last index, so the set and the clear never target the same flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_fire && wr_cnt == LAST_IDX)   full[wr_bank] <= 1'b1;
      if (rd_issue && rd_cnt == LAST_IDX)  full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_issue) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_cnt == LAST_IDX) rd_bank <= !rd_bank;
    end
  end

  sdp_ram #(
    .DW (W),
    .AW (LOG2N + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (in_data),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_first <= 1'b0;
      pend_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_first <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      pend_valid <= rd_issue;
      pend_first <= rd_issue && (rd_cnt == '0);
      pend_last  <= rd_issue && (rd_cnt == LAST_IDX);

      if (out_valid && !out_ready) begin
        // Head is stalled: park an arriving read word in the skid entry.
        if (pend_valid) begin
          skid_valid <= 1'b1;
          skid_data  <= rd_data;
          skid_first <= pend_first;
          skid_last  <= pend_last;
        end
      end else if (skid_valid) begin
        // Head empties: the older skid word advances, a new word refills it.
        out_data   <= skid_data;
        out_first  <= skid_first;
        out_last   <= skid_last;
        skid_valid <= pend_valid;
        if (pend_valid) begin
          skid_data  <= rd_data;
          skid_first <= pend_first;
          skid_last  <= pend_last;
        end
      end else begin
        out_valid <= pend_valid;
        out_first <= pend_valid && pend_first;
        out_last  <= pend_valid && pend_last;
        if (pend_valid) out_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_reorder.sv
// Self-checking bench for frame_reorder (DBW=8, CH=2, LOG2N=3).
// A behavioural model collects each accepted frame, permutes it from the
// mode definitions and queues the expected output stream; a negedge monitor
// compares every output handshake against that queue.
module tb_frame_reorder;

  localparam int DBW   = 8;
  localparam int CH    = 2;
  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int W     = DBW * CH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;

  frame_reorder #(
    .DBW   (DBW),
    .CH    (CH),
    .LOG2N (LOG2N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] frame_buf [N];
  int           wr_idx   = 0;
  logic [1:0]   cur_mode = '0;
  int           acc_cnt  = 0;
  int           run_len  = 0;
  int           max_run  = 0;
  bit           watch_ready = 1'b0;

  // Source sample feeding output position k of a frame.
  function automatic int src_index(input logic [1:0] mode, input int k);
    int r;
    case (mode)
      2'd1: r = (k % 2 == 0) ? k / 2 : N / 2 + k / 2;  // first/second half alternate
      2'd2: begin
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = (r << 1) | ((k >> b) & 1);
      end
      default: r = k;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (wr_idx == 0) cur_mode = in_mode;
        frame_buf[wr_idx] = in_data;
        wr_idx++;
        if (wr_idx == N) begin
          for (int k = 0; k < N; k++) begin
            e.data  = frame_buf[src_index(cur_mode, k)];
            e.first = (k == 0);
            e.last  = (k == N - 1);
            exp_q.push_back(e);
          end
          wr_idx = 0;
        end
      end
      if (watch_ready && in_valid) check("b2b_in_ready", in_ready, 1);
      if (out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_first", out_first, e.first);
          check("out_last", out_last, e.last);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_sample(input logic [W-1:0] d, input logic [1:0] m);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pair(input logic [7:0] v);
    logic [7:0] hi;
    hi = v + 8'h80;
    return {hi, v};
  endfunction

  task automatic push_frame(input logic [7:0] base, input logic [1:0] m);
    for (int k = 0; k < N; k++) push_sample(pair(base + 8'(k)), m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit drv_done;
    int guard;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Half-interleave frame with latency check: first output two cycles
    // after the last accepted sample.
    push_frame(8'h00, 2'd1);
    @(negedge clk);
    check("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t1b_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_first", out_first, 1);
    wait_drain("drain_half");

    // Bit-reverse, natural, reserved
    push_frame(8'h00, 2'd2);
    wait_drain("drain_brev");
    push_frame(8'h00, 2'd0);
    wait_drain("drain_nat");
    push_frame(8'h00, 2'd3);
    wait_drain("drain_rsvd");

    // Three frames back-to-back: continuous output, in_ready never low
    max_run     = 0;
    watch_ready = 1'b1;
    push_frame(8'h10, 2'd1);
    push_frame(8'h20, 2'd2);
    push_frame(8'h30, 2'd0);
    watch_ready = 1'b0;
    wait_drain("drain_b2b");
    check("b2b_continuous", max_run, 24);

    // Output backpressure while frames keep streaming in
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        push_frame(8'h00, 2'd1);
        push_frame(8'h08, 2'd2);
        push_frame(8'h10, 2'd0);
      end
      begin
        guard = 0;
        while (!out_valid && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        check("bp_first_out", out_valid, 1);
        repeat (20) begin
          @(negedge clk);
          check("bp_hold_data", out_data, 16'h8000);
          check("bp_hold_first", out_first, 1);
        end
        check("bp_accepted", acc_cnt, 16);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_bp");

    // Randomised frames, modes, input gaps and output backpressure
    drv_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          logic [1:0] fm;
          fm = 2'($urandom_range(3, 0));
          for (int k = 0; k < N; k++) begin
            if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
            push_sample(W'($urandom), (k == 0) ? fm : 2'($urandom));
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(2, 0) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_rand");

    // Asynchronous reset in mid-frame with a held output
    out_ready = 1'b0;
    push_frame(8'h40, 2'd2);
    for (int k = 0; k < 5; k++) push_sample(pair(8'h50 + 8'(k)), 2'd1);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    wr_idx = 0;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    push_frame(8'h60, 2'd1);
    wait_drain("drain_post_rst");

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
